// File: rtl/typing_test_ctrl_if.sv
// Keypad/tick/random-word inputs and the score/display outputs of the typing-test controller.
interface typing_test_ctrl_if #(
    parameter int WORD_DIGITS = 4
) ();
    logic                     sec_tick;
    logic                     key_valid;
    logic [3:0]               key_code;
    logic [4*WORD_DIGITS-1:0] rand_digits;
    logic [1:0]               state;
    logic                     goal_mode;
    logic [4*WORD_DIGITS-1:0] disp_digits;
    logic [WORD_DIGITS-1:0]   disp_en;
    logic [15:0]              words_done;
    logic [15:0]              elapsed;
    logic [6:0]               acc_pct;
    logic [15:0]              wpm;
    logic                     result_valid;
    logic                     done;

    modport master (
        output sec_tick, key_valid, key_code, rand_digits,
        input  state, goal_mode, disp_digits, disp_en, words_done, elapsed,
               acc_pct, wpm, result_valid, done
    );

    modport slave (
        input  sec_tick, key_valid, key_code, rand_digits,
        output state, goal_mode, disp_digits, disp_en, words_done, elapsed,
               acc_pct, wpm, result_valid, done
    );
endinterface

// File: rtl/typing_test_ctrl.sv
// Typing-test controller: goal entry, word/time-goal test with per-key scoring, and accuracy/WPM
// on one shared restoring divider. Key effects show one cycle after the press; divider jobs take DIV_W cycles.
module typing_test_ctrl #(
    parameter int WORD_DIGITS = 4,
    parameter int GOAL_DIGITS = 4,
    parameter int DIV_W       = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    typing_test_ctrl_if.slave bus
);
    localparam int PTR_W   = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam int ENTRY_W = 4 * GOAL_DIGITS;
    localparam int WORD_W  = 4 * WORD_DIGITS;
    localparam int DEN_W   = 17;    // correct+missed can exceed 16 bits once both counters are large
    localparam int CNT_W   = $clog2(DIV_W + 1);
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(WORD_DIGITS - 1);

    typedef enum logic [1:0] {S_SELECT = 2'd0, S_TEST = 2'd1, S_RESULT = 2'd2} state_t;
    typedef enum logic {J_ACC = 1'b0, J_WPM = 1'b1} job_t;

    state_t               state_q;
    job_t                 div_job_q;
    logic                 goal_mode_q, key_prev_q, done_q, rv_q;
    logic [ENTRY_W-1:0]   entry_q;
    logic [15:0]          goal_q, correct_q, missed_q, words_q, elapsed_q, wpm_q;
    logic [WORD_W-1:0]    word_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [WORD_DIGITS-1:0] en_q;
    logic [6:0]           acc_q;
    logic                 div_busy_q, acc_pend_q, wpm_pend_q;
    logic [CNT_W-1:0]     div_cnt_q;
    logic [DEN_W-1:0]     div_rem_q, div_den_q;
    logic [DIV_W-1:0]     div_quo_q;

    logic                 key_ev, is_digit, in_test, quit, hit, miss, word_fin, tick, finish;
    logic                 start, leave, acc_req;
    logic [3:0]           cur_digit;
    logic [15:0]          correct_nx, missed_nx, words_nx, elapsed_nx, wpm_sat;
    logic [DIV_W-1:0]     acc_num, wpm_num, quo_step;
    logic [DEN_W-1:0]     acc_den, rem_step;
    logic [DEN_W:0]       rem_sh, diff;
    logic [WORD_W-1:0]    disp;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] bcd_to_bin(input logic [ENTRY_W-1:0] e);
        logic [15:0] v;
        v = '0;
        for (int i = GOAL_DIGITS - 1; i >= 0; i--)
            v = v * 16'd10 + 16'(e[4*i +: 4]);
        return v;
    endfunction

    always_comb begin
        key_ev    = bus.key_valid & ~key_prev_q;
        is_digit  = (bus.key_code <= 4'd9);
        cur_digit = '0;
        for (int i = 0; i < WORD_DIGITS; i++)
            if (ptr_q == PTR_W'(i)) cur_digit = word_q[4*i +: 4];
        in_test  = (state_q == S_TEST);
        quit     = in_test & key_ev & (bus.key_code == 4'hB);
        hit      = in_test & key_ev & is_digit & (bus.key_code == cur_digit);
        miss     = in_test & key_ev & is_digit & (bus.key_code != cur_digit);
        word_fin = hit & (ptr_q == '0);
        tick     = in_test & bus.sec_tick;
        start    = (state_q == S_SELECT) & key_ev & (bus.key_code == 4'hA) & (entry_q != '0);
        leave    = (state_q == S_RESULT) & key_ev & (bus.key_code == 4'hB);

        correct_nx = hit      ? sat_inc(correct_q) : correct_q;
        missed_nx  = miss     ? sat_inc(missed_q)  : missed_q;
        words_nx   = word_fin ? sat_inc(words_q)   : words_q;
        elapsed_nx = tick     ? sat_inc(elapsed_q) : elapsed_q;
        // A completing word is counted before the end test, so a simultaneous tick and word both land.
        finish = in_test & ~quit &
                 ((~goal_mode_q & word_fin & (words_nx == goal_q)) |
                  (goal_mode_q & tick & (elapsed_nx == goal_q)));
        acc_req = acc_pend_q | hit | miss | finish;

        acc_num = DIV_W'(32'(correct_nx) * 32'd100);
        acc_den = DEN_W'(correct_nx) + DEN_W'(missed_nx);
        wpm_num = DIV_W'(32'(words_q) * 32'd60);

        rem_sh   = {div_rem_q, div_quo_q[DIV_W-1]};
        diff     = rem_sh - {1'b0, div_den_q};
        quo_step = {div_quo_q[DIV_W-2:0], ~diff[DEN_W]};
        rem_step = diff[DEN_W] ? rem_sh[DEN_W-1:0] : diff[DEN_W-1:0];
        wpm_sat  = (quo_step > DIV_W'(16'hFFFF)) ? 16'hFFFF : quo_step[15:0];

        disp = '0;
        for (int i = 0; i < WORD_DIGITS && i < GOAL_DIGITS; i++)
            disp[4*i +: 4] = entry_q[4*i +: 4];
        if (state_q != S_SELECT) disp = word_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_SELECT;
            goal_mode_q <= 1'b0;
            key_prev_q  <= 1'b0;
            done_q      <= 1'b0;
            rv_q        <= 1'b0;
            entry_q     <= '0;
            goal_q      <= '0;
            correct_q   <= '0;
            missed_q    <= '0;
            words_q     <= '0;
            elapsed_q   <= '0;
            wpm_q       <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            ptr_q       <= PTR_TOP;
            en_q        <= '1;
            div_busy_q  <= 1'b0;
            div_job_q   <= J_ACC;
            acc_pend_q  <= 1'b0;
            wpm_pend_q  <= 1'b0;
            div_cnt_q   <= '0;
            div_rem_q   <= '0;
            div_den_q   <= '0;
            div_quo_q   <= '0;
        end else begin
            key_prev_q <= bus.key_valid;
            done_q     <= 1'b0;

            if (div_busy_q) begin
                div_rem_q <= rem_step;
                div_quo_q <= quo_step;
                div_cnt_q <= div_cnt_q + 1'b1;
                if (div_cnt_q == CNT_W'(DIV_W - 1)) begin
                    div_busy_q <= 1'b0;
                    if (div_job_q == J_ACC) acc_q <= quo_step[6:0];
                    else begin
                        wpm_q <= wpm_sat;
                        rv_q  <= 1'b1;
                    end
                end
                if (hit | miss | finish) acc_pend_q <= 1'b1;
            end else if (acc_req) begin
                acc_pend_q <= 1'b0;
                if (acc_den == '0) acc_q <= '0;
                else begin
                    div_busy_q <= 1'b1;
                    div_job_q  <= J_ACC;
                    div_cnt_q  <= '0;
                    div_rem_q  <= '0;
                    div_quo_q  <= acc_num;
                    div_den_q  <= acc_den;
                end
            end else if (wpm_pend_q) begin
                wpm_pend_q <= 1'b0;
                if (elapsed_q == '0) begin
                    wpm_q <= '0;
                    rv_q  <= 1'b1;
                end else begin
                    div_busy_q <= 1'b1;
                    div_job_q  <= J_WPM;
                    div_cnt_q  <= '0;
                    div_rem_q  <= '0;
                    div_quo_q  <= wpm_num;
                    div_den_q  <= {1'b0, elapsed_q};
                end
            end

            case (state_q)
                S_SELECT: begin
                    if (key_ev) begin
                        if (is_digit) entry_q <= ENTRY_W'({entry_q, bus.key_code});
                        else if (bus.key_code == 4'hB) entry_q <= '0;
                        else if (bus.key_code == 4'hC) goal_mode_q <= ~goal_mode_q;
                        else if (start) begin
                            goal_q  <= bcd_to_bin(entry_q);
                            word_q  <= bus.rand_digits;
                            ptr_q   <= PTR_TOP;
                            state_q <= S_TEST;
                        end
                    end
                end
                S_TEST: begin
                    if (quit) state_q <= S_SELECT;
                    else begin
                        correct_q <= correct_nx;
                        missed_q  <= missed_nx;
                        words_q   <= words_nx;
                        elapsed_q <= elapsed_nx;
                        if (hit) begin
                            if (word_fin) begin
                                word_q <= bus.rand_digits;
                                ptr_q  <= PTR_TOP;
                                en_q   <= '1;
                            end else begin
                                en_q[ptr_q] <= 1'b0;
                                ptr_q       <= ptr_q - 1'b1;
                            end
                        end
                        if (finish) begin
                            state_q    <= S_RESULT;
                            done_q     <= 1'b1;
                            en_q       <= '0;
                            wpm_pend_q <= 1'b1;
                        end
                    end
                end
                S_RESULT: if (leave) state_q <= S_SELECT;
                default:  state_q <= S_SELECT;
            endcase

            // Entering or leaving a test wipes statistics and abandons any divide in flight.
            if (start | quit | leave) begin
                correct_q  <= '0;
                missed_q   <= '0;
                words_q    <= '0;
                elapsed_q  <= '0;
                acc_q      <= '0;
                wpm_q      <= '0;
                rv_q       <= 1'b0;
                en_q       <= '1;
                div_busy_q <= 1'b0;
                acc_pend_q <= 1'b0;
                wpm_pend_q <= 1'b0;
            end
        end
    end

    assign bus.state        = state_q;
    assign bus.goal_mode    = goal_mode_q;
    assign bus.disp_digits  = disp;
    assign bus.disp_en      = en_q;
    assign bus.words_done   = words_q;
    assign bus.elapsed      = elapsed_q;
    assign bus.acc_pct      = acc_q;
    assign bus.wpm          = wpm_q;
    assign bus.result_valid = rv_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_typing_test_ctrl.sv
// Directed and randomized bench for typing_test_ctrl against a score-level reference model.
module tb_typing_test_ctrl;
    localparam int WD    = 4;
    localparam int DIV_W = 24;

    logic clk = 1'b0;
    logic rst_n;
    typing_test_ctrl_if #(.WORD_DIGITS(WD)) bus ();

    typing_test_ctrl #(.WORD_DIGITS(WD), .GOAL_DIGITS(4), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: what a person scoring the test by hand would track.
    int m_state, m_mode, m_goal, m_c, m_m, m_w, m_e, m_typed, m_done;
    logic [4*WD-1:0] m_word;
    int en_seq[4] = '{7, 3, 1, 15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*WD-1:0] rand_bcd();
        logic [4*WD-1:0] r;
        for (int i = 0; i < WD; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    function automatic int exp_digit();
        return int'((m_word >> (4 * (WD - 1 - m_typed))) & 16'hF);
    endfunction

    function automatic int exp_en();
        if (m_state == 0) return (1 << WD) - 1;
        if (m_state == 2) return 0;
        return (1 << (WD - m_typed)) - 1;
    endfunction

    function automatic int exp_acc();
        return (m_c + m_m == 0) ? 0 : (100 * m_c) / (m_c + m_m);
    endfunction

    function automatic int exp_wpm();
        int v;
        v = (m_e == 0) ? 0 : (m_w * 60) / m_e;
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_start(input int goal, input int mode, input logic [4*WD-1:0] w);
        m_state = 1; m_mode = mode; m_goal = goal; m_word = w;
        m_c = 0; m_m = 0; m_w = 0; m_e = 0; m_typed = 0; m_done = 0;
    endtask

    task automatic model_key(input int d, input bit tk);
        bit fin;
        fin = 0;
        if (d == exp_digit()) begin
            m_c++;
            m_typed++;
            if (m_typed == WD) begin
                m_w++;
                m_typed = 0;
                m_word = bus.rand_digits;
                if (m_mode == 0 && m_w == m_goal) fin = 1;
            end
        end else m_m++;
        if (tk) begin
            m_e++;
            if (m_mode == 1 && m_e == m_goal) fin = 1;
        end
        if (fin) begin m_state = 2; m_done = 1; end
    endtask

    task automatic model_tick();
        m_e++;
        if (m_mode == 1 && m_e == m_goal) begin m_state = 2; m_done = 1; end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"}, bus.state, m_state);
        chk({tag, "_words"}, bus.words_done, m_w);
        chk({tag, "_elapsed"}, bus.elapsed, m_e);
        chk({tag, "_en"}, bus.disp_en, exp_en());
        chk({tag, "_disp"}, bus.disp_digits, m_word);
        chk({tag, "_done"}, bus.done, m_done);
        m_done = 0;
    endtask

    task automatic press(input logic [3:0] code, input bit tk, input int hold);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        bus.sec_tick  = tk;
        @(negedge clk);
        bus.sec_tick = 1'b0;
        repeat (hold - 1) @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic tick_pulse();
        @(negedge clk);
        bus.sec_tick = 1'b1;
        @(negedge clk);
        bus.sec_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rv(input int bound, input string tag);
        int n;
        n = 0;
        while (bus.result_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.result_valid, 1);
    endtask

    task automatic enter_goal(input logic [15:0] bcd);
        for (int i = 3; i >= 0; i--) press(bcd[4*i +: 4], 1'b0, 1);
    endtask

    task automatic check_cleared(input string tag, input logic [15:0] disp_exp);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_words"}, bus.words_done, 0);
        chk({tag, "_elapsed"}, bus.elapsed, 0);
        chk({tag, "_acc"}, bus.acc_pct, 0);
        chk({tag, "_wpm"}, bus.wpm, 0);
        chk({tag, "_rv"}, bus.result_valid, 0);
        chk({tag, "_en"}, bus.disp_en, 4'hF);
        chk({tag, "_disp"}, bus.disp_digits, disp_exp);
    endtask

    initial begin
        logic [4*WD-1:0] w;
        int d, steps;
        bit tk;

        rst_n = 1'b0;
        bus.sec_tick = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code = 4'h0;
        bus.rand_digits = 16'h1234;
        idle(3);
        check_cleared("reset", 16'h0000);
        chk("reset_mode", bus.goal_mode, 0);
        chk("reset_done", bus.done, 0);
        rst_n = 1'b1;

        // Word goal of 2: first word 1234 with explicit enable progression.
        enter_goal(16'h0002);
        chk("entry_disp", bus.disp_digits, 16'h0002);
        press(4'hA, 1'b0, 1);
        model_start(2, 0, 16'h1234);
        chk("start_state", bus.state, 1);
        chk("start_disp", bus.disp_digits, 16'h1234);
        chk("start_en", bus.disp_en, 4'hF);
        bus.rand_digits = 16'h5678;
        for (int i = 0; i < 4; i++) begin
            model_key(i + 1, 1'b0);
            press(4'(i + 1), 1'b0, 1);
            chk("w1_en_seq", bus.disp_en, en_seq[i]);
            check_all("w1");
            idle(DIV_W + 4);
        end
        chk("w1_words", bus.words_done, 1);
        for (int i = 0; i < 30; i++) begin
            model_tick();
            tick_pulse();
        end
        chk("ticks30", bus.elapsed, 30);
        for (int i = 0; i < 4; i++) begin
            model_key(i + 5, 1'b0);
            press(4'(i + 5), 1'b0, 1);
            check_all("w2");
            if (i < 3) idle(DIV_W + 4);
        end
        chk("w2_done", bus.done, 1);
        wait_rv(2 * DIV_W + 4, "w2_rv");
        chk("w2_acc", bus.acc_pct, 100);
        chk("w2_wpm", bus.wpm, 4);
        chk("w2_done_low", bus.done, 0);

        press(4'hB, 1'b0, 1);
        check_cleared("res_clear", 16'h0002);

        // 3 correct + 1 wrong, first key held 100 cycles.
        w = rand_bcd();
        bus.rand_digits = w;
        press(4'hA, 1'b0, 1);
        model_start(2, 0, w);
        check_all("acc_start");
        d = exp_digit();
        model_key(d, 1'b0);
        press(4'(d), 1'b0, 100);
        check_all("hold");
        d = exp_digit();
        model_key(d, 1'b0);
        press(4'(d), 1'b0, 1);
        d = (exp_digit() + 1) % 10;
        model_key(d, 1'b0);
        press(4'(d), 1'b0, 1);
        check_all("wrong");
        d = exp_digit();
        model_key(d, 1'b0);
        press(4'(d), 1'b0, 1);
        idle(2 * DIV_W + 4);
        chk("acc75", bus.acc_pct, 75);
        chk("acc75_en", bus.disp_en, 4'b0001);

        press(4'hB, 1'b0, 1);
        check_cleared("quit", 16'h0002);
        chk("quit_mode", bus.goal_mode, 0);

        // Time goal of 5 seconds with one word typed.
        press(4'hC, 1'b0, 1);
        chk("mode_toggle", bus.goal_mode, 1);
        enter_goal(16'h0005);
        w = rand_bcd();
        bus.rand_digits = w;
        press(4'hA, 1'b0, 1);
        model_start(5, 1, w);
        for (int i = 0; i < 2; i++) begin model_tick(); tick_pulse(); check_all("t_pre"); end
        bus.rand_digits = rand_bcd();
        for (int i = 0; i < WD; i++) begin
            d = exp_digit();
            model_key(d, 1'b0);
            press(4'(d), 1'b0, 1);
            idle(DIV_W + 4);
        end
        for (int i = 0; i < 3; i++) begin model_tick(); tick_pulse(); check_all("t_tick"); end
        chk("t_state", bus.state, 2);
        wait_rv(2 * DIV_W + 4, "t_rv");
        chk("t_wpm", bus.wpm, 12);
        chk("t_acc", bus.acc_pct, 100);
        press(4'hB, 1'b0, 1);
        chk("t_mode_kept", bus.goal_mode, 1);

        // Randomized word-goal session.
        press(4'hC, 1'b0, 1);
        enter_goal(16'h0003);
        w = rand_bcd();
        bus.rand_digits = w;
        press(4'hA, 1'b0, 1);
        model_start(3, 0, w);
        steps = 0;
        while (m_state == 1 && steps < 300) begin
            bus.rand_digits = rand_bcd();
            d = ($urandom_range(0, 9) < 7) ? exp_digit() : (exp_digit() + 1 + $urandom_range(0, 8)) % 10;
            tk = ($urandom_range(0, 3) == 0);
            model_key(d, tk);
            press(4'(d), tk, 1);
            check_all("rnd");
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 30));
            steps++;
        end
        chk("rnd_end", bus.state, 2);
        wait_rv(3 * DIV_W + 8, "rnd_rv");
        chk("rnd_acc", bus.acc_pct, exp_acc());
        chk("rnd_wpm", bus.wpm, exp_wpm());

        // Word goal 1: last key coincides with a tick.
        press(4'hB, 1'b0, 1);
        enter_goal(16'h0001);
        w = rand_bcd();
        bus.rand_digits = w;
        press(4'hA, 1'b0, 1);
        model_start(1, 0, w);
        for (int i = 0; i < WD; i++) begin
            d = exp_digit();
            tk = (i == WD - 1);
            model_key(d, tk);
            press(4'(d), tk, 1);
            check_all("coinc");
        end
        chk("coinc_words", bus.words_done, 1);
        chk("coinc_elapsed", bus.elapsed, 1);

        // Reset while the final divide is in progress.
        idle(5);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("rst_mid", 16'h0000);
        chk("rst_mid_mode", bus.goal_mode, 0);
        rst_n = 1'b1;
        idle(2 * DIV_W + 4);
        chk("rst_mid_rv", bus.result_valid, 0);
        chk("rst_mid_acc", bus.acc_pct, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
